oam_dma_bridge: RTL and testbench
=================================

OAM_DMA_BRIDGE -- requirements
Module: oam_dma_bridge

Interface
REQ-001 SHALL have parameter DMA_LEN, default 160, bytes copied per transfer.
REQ-002 SHALL have parameter DMA_REG, default 16'hFF46, DMA start/source register address.
REQ-003 SHALL have parameter OAM_BASE, default 16'hFE00, destination base address.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port cpu_addr  in  16  address from the sm83 core.
REQ-007 SHALL have port cpu_d_out  in  8  write data from the core.
REQ-008 SHALL have port cpu_write  in  1  core write strobe, sampled each clk edge.
REQ-009 SHALL have port cpu_d_in  out  8  read data to the core.
REQ-010 SHALL have port mem_addr  out  16  system memory bus address.
REQ-011 SHALL have port mem_d_out  out  8  system memory bus write data.
REQ-012 SHALL have port mem_write  out  1  system memory bus write strobe.
REQ-013 SHALL have port mem_d_in  in  8  system memory bus read data.
REQ-014 SHALL have port dma_active  out  1  high while a transfer owns the memory bus.

Function
REQ-015 SHALL contain 127-byte HRAM at FF80-FFFE: combinational read, write on the clk edge when cpu_write=1; HRAM accesses never reach the memory bus, in any state.
REQ-016 SHALL implement FSM IDLE -> START -> READ <-> WRITE -> IDLE; dma_active=1 in START, READ and WRITE.
REQ-017 SHALL, on cpu_write=1 with cpu_addr=DMA_REG, latch cpu_d_out as source page and index=0, and enter START next cycle, from any state.
REQ-018 SHALL map source page >= 8'hE0 to page-8'h20 (echo region to C0-DF).
REQ-019 SHALL in START drive the memory bus idle (mem_write=0, mem_addr=0) for exactly one cycle.
REQ-020 SHALL in READ drive mem_addr={page,8'h00}+index, mem_write=0, and capture mem_d_in into a byte buffer at the end of the cycle.
REQ-021 SHALL in WRITE drive mem_addr=OAM_BASE+index, mem_d_out=buffer, mem_write=1, then increment index.
REQ-022 SHALL go WRITE -> IDLE when index=DMA_LEN-1, else WRITE -> READ; one transfer = 1+2*DMA_LEN cycles (321 default).
REQ-023 SHALL give a DMA_REG write in the same cycle as the final WRITE priority: the final write completes, next state START.
REQ-024 SHALL, on restart during WRITE, complete that cycle's mem_write before restarting; on restart during READ, discard the captured byte.
REQ-025 SHALL in IDLE forward non-HRAM, non-DMA_REG CPU accesses combinationally: mem_addr=cpu_addr, mem_d_out=cpu_d_out, mem_write=cpu_write, cpu_d_in=mem_d_in.
REQ-026 SHALL, while dma_active=1, return 8'hFF for CPU reads outside HRAM/DMA_REG and drop such CPU writes.
REQ-027 SHALL never forward DMA_REG writes to the memory bus.

Reset
REQ-028 SHALL on rst=1: state IDLE, index 0, page 0, buffer 0, dma_active 0; HRAM contents not reset.
REQ-029 SHALL, on rst asserted mid-transfer, abort with no further mem_write after the reset edge.

Configuration
REQ-030 SHALL with OAM_DMA_READBACK_EN defined return the last written DMA_REG value (raw, before REQ-018 mapping) on CPU reads of DMA_REG; without it such reads return 8'hFF.

Structure
REQ-031 SHALL place FSM state enum and HRAM bounds (FF80, FFFE) in the shared package alongside existing sm83 typedefs.
REQ-032 SHALL implement HRAM as sub-module hram_m (127x8, async read, sync write).

Verification
REQ-033 Write 8'hC1 to FF46, memory C100+i=i -> FE00..FE9F = 00..9F, dma_active high 321 cycles.
REQ-034 During transfer CPU reads C000 -> 8'hFF; CPU writes FF90=5A then reads FF90 -> 5A; CPU write to C000 dropped.
REQ-035 Write 8'hE2 -> source read from C200..C29F.
REQ-036 Write C1, then write C3 at cycle 100 -> restart; final FE00.. holds C300 data, total active 100+321 cycles.
REQ-037 rst at cycle 50 of transfer -> dma_active 0 next cycle, no mem_write afterwards; read FF46 -> C1 with OAM_DMA_READBACK_EN, FF without.

Source files
------------

// File: rtl/oam_dma_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | oam_dma_bridge_pkg                                                 |
// | Shared sm83 bus types, DMA FSM encoding and HRAM window constants. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package oam_dma_bridge_pkg;

  typedef logic [15:0] sm83_addr_t;
  typedef logic [7:0]  sm83_data_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } dma_state_t;

  localparam sm83_addr_t HRAM_LO    = 16'hFF80;
  localparam sm83_addr_t HRAM_HI    = 16'hFFFE;
  localparam int         HRAM_DEPTH = 127;
  localparam int         HRAM_AW    = 7;

  function automatic logic is_hram(input sm83_addr_t a);
    return (a >= HRAM_LO) && (a <= HRAM_HI);
  endfunction

  // Pages E0..FF are the echo of C0..DF
  function automatic sm83_data_t echo_map(input sm83_data_t p);
    return (p >= 8'hE0) ? (p - 8'h20) : p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma_bridge_hram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hram_m                                                             |
// | 127x8 high RAM: asynchronous read, synchronous write.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module hram_m
  import oam_dma_bridge_pkg::*;
(
  input  logic               clk,
  input  logic               i_we,
  input  logic [HRAM_AW-1:0] i_addr,
  input  logic [7:0]         i_wdata,
  output logic [7:0]         o_rdata
);

  logic [7:0] r_mem [0:HRAM_DEPTH-1];
  logic       w_in_range;

  // Offset 7F would be FFFF, which lies outside the array
  assign w_in_range = (i_addr != 7'h7F);

  always_ff @(posedge clk) begin
    if (i_we && w_in_range) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = w_in_range ? r_mem[i_addr] : 8'hFF;

endmodule
`default_nettype wire

// File: rtl/oam_dma_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | oam_dma_bridge                                                     |
// | sm83 bus bridge with OAM DMA engine and HRAM. Optional macro       |
// | OAM_DMA_READBACK_EN makes the DMA register readable.               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module oam_dma_bridge
  import oam_dma_bridge_pkg::*;
#(
  parameter int          DMA_LEN  = 160,
  parameter logic [15:0] DMA_REG  = 16'hFF46,
  parameter logic [15:0] OAM_BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  output logic [7:0]  cpu_d_in,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_d_out,
  output logic        mem_write,
  input  logic [7:0]  mem_d_in,
  output logic        dma_active
);

  localparam int             IDX_W      = (DMA_LEN > 1) ? $clog2(DMA_LEN) : 1;
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DMA_LEN - 1);

  dma_state_t       r_state;
  dma_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_page;
  logic [7:0]       r_buf;

  logic        w_hram;
  logic        w_is_dmareg;
  logic        w_dma_wr;
  logic        w_last;
  logic [15:0] w_idx16;
  logic [7:0]  w_hram_rdata;
  logic [7:0]  w_reg_rdata;

  assign w_hram      = is_hram(cpu_addr);
  assign w_is_dmareg = (cpu_addr == DMA_REG);
  assign w_dma_wr    = cpu_write && w_is_dmareg;
  assign w_last      = (r_idx == C_IDX_LAST);
  assign w_idx16     = 16'(r_idx);
  assign dma_active  = (r_state != ST_IDLE);

  hram_m u_hram (
    .clk     (clk),
    .i_we    (cpu_write && w_hram),
    .i_addr  (cpu_addr[HRAM_AW-1:0]),
    .i_wdata (cpu_d_out),
    .o_rdata (w_hram_rdata)
  );

`ifdef OAM_DMA_READBACK_EN
  // Holds the raw written value and deliberately survives reset
  logic [7:0] r_dma_reg_raw;
  always_ff @(posedge clk) begin
    if (w_dma_wr) begin
      r_dma_reg_raw <= cpu_d_out;
    end
  end
  assign w_reg_rdata = r_dma_reg_raw;
`else
  assign w_reg_rdata = 8'hFF;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_page  <= 8'h00;
      r_buf   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_dma_wr) begin
        r_page <= echo_map(cpu_d_out);
        r_idx  <= '0;
      end else if (r_state == ST_WRITE) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
      // A restart landing on a READ cycle drops that byte
      if ((r_state == ST_READ) && !w_dma_wr) begin
        r_buf <= mem_d_in;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_dma_wr) begin
      w_state_nxt = ST_START;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_START: w_state_nxt = ST_READ;
        ST_READ:  w_state_nxt = ST_WRITE;
        ST_WRITE: w_state_nxt = w_last ? ST_IDLE : ST_READ;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = 16'h0000;
    mem_d_out = 8'h00;
    mem_write = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_hram && !w_is_dmareg) begin
          mem_addr  = cpu_addr;
          mem_d_out = cpu_d_out;
          mem_write = cpu_write;
        end
      end
      ST_READ: begin
        mem_addr = {r_page, 8'h00} + w_idx16;
      end
      ST_WRITE: begin
        mem_addr  = OAM_BASE + w_idx16;
        mem_d_out = r_buf;
        mem_write = 1'b1;
      end
      default: begin
        mem_addr = 16'h0000;
      end
    endcase
  end

  always_comb begin
    cpu_d_in = 8'hFF;
    if (w_hram) begin
      cpu_d_in = w_hram_rdata;
    end else if (w_is_dmareg) begin
      cpu_d_in = w_reg_rdata;
    end else if (r_state == ST_IDLE) begin
      cpu_d_in = mem_d_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_oam_dma_bridge                                                  |
// | Scoreboard bench: expected bus writes queued at stimulus time.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_oam_dma_bridge;

  localparam int          DMA_LEN  = 160;
  localparam logic [15:0] DMA_REG  = 16'hFF46;
  localparam logic [15:0] OAM_BASE = 16'hFE00;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_write;
  logic [7:0]  cpu_d_in;
  logic [15:0] mem_addr;
  logic [7:0]  mem_d_out;
  logic        mem_write;
  logic [7:0]  mem_d_in;
  logic        dma_active;

  logic [7:0] sysmem  [0:65535];
  logic [7:0] ref_mem [0:65535];
  exp_t       q[$];
  exp_t       mon_e;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         active_cnt = 0;

  oam_dma_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_d_out  (cpu_d_out),
    .cpu_write  (cpu_write),
    .cpu_d_in   (cpu_d_in),
    .mem_addr   (mem_addr),
    .mem_d_out  (mem_d_out),
    .mem_write  (mem_write),
    .mem_d_in   (mem_d_in),
    .dma_active (dma_active)
  );

  assign mem_d_in = sysmem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Bus memory and write monitor
  always @(negedge clk) begin
    if (dma_active) active_cnt++;
    if (mem_write === 1'b1) begin
      sysmem[mem_addr] = mem_d_out;
      if (q.size() == 0) begin
        chk("unexpected_write", {8'h00, mem_addr, mem_d_out}, 32'h0);
      end else begin
        mon_e = q.pop_front();
        chk("bus_write", {8'h00, mem_addr, mem_d_out}, {8'h00, mon_e.a, mon_e.d});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, input bit fwd);
    cpu_addr  = a;
    cpu_d_out = d;
    cpu_write = 1'b1;
    if (fwd) begin
      q.push_back(exp_t'{a: a, d: d});
      ref_mem[a] = d;
    end
    cyc();
    cpu_write = 1'b0;
  endtask

  task automatic cpu_rd_chk(input logic [15:0] a, input logic [7:0] exp, input string nm);
    cpu_addr  = a;
    cpu_write = 1'b0;
    #2;
    chk(nm, {24'h0, cpu_d_in}, {24'h0, exp});
  endtask

  // Number of OAM writes that finish before an event sampled k edges after the start write
  function automatic int writes_before(input int k);
    int n;
    n = (k < 3) ? 0 : ((k - 3) / 2 + 1);
    return (n > DMA_LEN) ? DMA_LEN : n;
  endfunction

  task automatic push_xfer(input logic [7:0] page, input int n);
    logic [7:0]  src;
    logic [15:0] sa;
    src = (page >= 8'hE0) ? page - 8'h20 : page;
    for (int i = 0; i < n; i++) begin
      sa = {src, 8'h00} + 16'(i);
      q.push_back(exp_t'{a: OAM_BASE + 16'(i), d: ref_mem[sa]});
    end
  endtask

  task automatic dma_start(input logic [7:0] page, input bit chk_bus);
    cpu_addr  = DMA_REG;
    cpu_d_out = page;
    cpu_write = 1'b1;
    cyc();
    cpu_write = 1'b0;
    cpu_addr  = 16'h0000;
    if (chk_bus) begin
      chk("start_active", {31'h0, dma_active}, 32'h1);
      chk("start_bus_idle", {15'h0, mem_write, mem_addr}, 32'h0);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (dma_active && n < bound) begin
      cyc();
      n++;
    end
    chk("idle_reached", {31'h0, dma_active}, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [7:0]  pg;
    logic [15:0] ra;
    logic [7:0]  rd;
    logic [7:0]  rb_exp;
    for (int i = 0; i < 65536; i++) begin
      sysmem[i]  = 8'($urandom);
      ref_mem[i] = sysmem[i];
    end
    for (int i = 0; i < DMA_LEN; i++) begin
      sysmem[16'hC100 + i]  = 8'(i);
      ref_mem[16'hC100 + i] = 8'(i);
    end
`ifdef OAM_DMA_READBACK_EN
    rb_exp = 8'hC1;
`else
    rb_exp = 8'hFF;
`endif
    rst = 1'b1; cpu_addr = 16'h0000; cpu_d_out = 8'h00; cpu_write = 1'b0;
    repeat (3) cyc();
    chk("reset_active", {31'h0, dma_active}, 32'h0);
    chk("reset_mem_write", {31'h0, mem_write}, 32'h0);
    rst = 1'b0;
    cyc();

    // Idle forwarding of writes and reads
    for (int t = 0; t < 4; t++) begin
      ra = 16'h8000 + 16'($urandom_range(0, 16'h5FFF));
      rd = 8'($urandom);
      cpu_wr(ra, rd, 1'b1);
      cpu_rd_chk(ra, ref_mem[ra], "fwd_read");
    end

    // Basic transfer from C1 with CPU activity while busy
    push_xfer(8'hC1, DMA_LEN);
    active_cnt = 0;
    dma_start(8'hC1, 1'b1);
    repeat (10) cyc();
    cpu_rd_chk(16'hC000, 8'hFF, "busy_read");
    cpu_wr(16'hFF90, 8'h5A, 1'b0);
    cpu_rd_chk(16'hFF90, 8'h5A, "hram_rw");
    cpu_wr(16'hC000, 8'hA5, 1'b0);
    cpu_rd_chk(DMA_REG, rb_exp, "dma_reg_read");
    wait_idle(400);
    chk("active_cycles", active_cnt, 32'd321);
    chk("queue_drained", q.size(), 32'd0);
    cpu_rd_chk(16'hC000, ref_mem[16'hC000], "dropped_write");
    chk("oam_last", {24'h0, sysmem[OAM_BASE + 16'(DMA_LEN - 1)]}, 32'h9F);

    // Echo page source
    push_xfer(8'hE2, DMA_LEN);
    dma_start(8'hE2, 1'b1);
    wait_idle(400);
    chk("echo_drained", q.size(), 32'd0);

    // Restart at cycle 100
    push_xfer(8'hC1, writes_before(100));
    active_cnt = 0;
    dma_start(8'hC1, 1'b0);
    repeat (99) cyc();
    push_xfer(8'hC3, DMA_LEN);
    dma_start(8'hC3, 1'b1);
    wait_idle(400);
    chk("restart_cycles", active_cnt, 32'd421);
    chk("restart_drained", q.size(), 32'd0);

    // Random source pages
    for (int t = 0; t < 3; t++) begin
      pg = 8'($urandom_range(8'hC0, 8'hFD));
      push_xfer(pg, DMA_LEN);
      active_cnt = 0;
      dma_start(pg, 1'b1);
      wait_idle(400);
      chk("rand_cycles", active_cnt, 32'd321);
      chk("rand_drained", q.size(), 32'd0);
    end

    // Reset mid-transfer
    push_xfer(8'hC1, writes_before(50));
    dma_start(8'hC1, 1'b0);
    repeat (49) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_abort_active", {31'h0, dma_active}, 32'h0);
    repeat (20) cyc();
    chk("rst_no_more_writes", q.size(), 32'd0);
    cpu_rd_chk(DMA_REG, rb_exp, "readback_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
